// File: rtl/memory_ctrl_pkg.sv
// memory_ctrl_pkg: shared constants and types for the CHIP-8 main memory.
//   FONT_BYTES          - size of the built-in hex font (16 glyphs x 5 bytes)
//   DEFAULT_ADDR_WIDTH  - default address width of the byte array
//   DEFAULT_DEPTH       - default depth in bytes
//   state_t             - controller FSM states (init sweep, fetch port)
package memory_ctrl_pkg;

   localparam int FONT_BYTES         = 80;
   localparam int DEFAULT_ADDR_WIDTH = 12;
   localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_IDLE     = 2'd1,
      ST_FETCH_LO = 2'd2
   } state_t;

endpackage

// File: rtl/memory_ctrl_font_rom.sv
// font_rom: combinational CHIP-8 hex font, glyphs 0-F, 5 bytes each.
//   index - byte index 0..79 (glyph*5 + row); indices >= 80 return 0
//   data  - glyph row byte
module font_rom
   import memory_ctrl_pkg::*;
(
   input  logic [6:0] index,
   output logic [7:0] data
);

   // Glyph 0 row 0 sits in the most significant byte.
   localparam logic [8*FONT_BYTES-1:0] GLYPHS = {
      8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
      8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
      8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
      8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
      8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
      8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
      8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
      8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
      8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
      8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
      8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
      8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
      8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
      8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
   };

   always_comb begin
      data = 8'h00;
      if (int'(index) < FONT_BYTES)
         data = GLYPHS[8*(FONT_BYTES-1-int'(index)) +: 8];
   end

endmodule

// File: rtl/memory_ctrl.sv
// memory_ctrl: CHIP-8 byte RAM with a read/write data port (A) and a
// 16-bit big-endian opcode fetch port (F). After reset a sweep zeroes the
// array (optional) and loads the hex font at FONT_BASE.
//   clk, reset           - clock, synchronous active-high reset
//   busy                 - reset asserted or init sweep in progress
//   read/read_addr       - port A read strobe/address, read_data 1 cycle later
//   write/write_addr/... - port A write, commits at the edge
//   fetch_req/fetch_addr - opcode fetch request, accepted when fetch_ready
//   fetch_valid          - one-cycle pulse, fetch_data = {mem[a], mem[a+1]}
// Fetch handshake: a request is taken on an edge where fetch_req and
// fetch_ready are both high; requests while fetch_ready is low are dropped,
// never queued. fetch_valid follows one cycle after the FETCH_LO cycle.
module memory_ctrl
   import memory_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] FONT_BASE      = '0,
   parameter bit                    CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  busy,
   input  logic                  read,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [7:0]            read_data,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [7:0]            write_data,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ready,
   output logic                  fetch_valid,
   output logic [15:0]           fetch_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // Full sweep covers the whole array; font-only sweep covers 80 bytes.
   localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST =
      CLEAR_ON_RESET ? {ADDR_WIDTH{1'b1}} : ADDR_WIDTH'(FONT_BYTES - 1);

   logic [7:0]            mem [DEPTH];
   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] sweep_ctr, sweep_addr, font_off;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_rd_addr;
   logic [7:0]            font_byte, sweep_byte, fetch_byte, hi_reg;
   logic                  in_font;

   // In font-only mode the counter is an offset into the font window.
   assign sweep_addr = CLEAR_ON_RESET ? sweep_ctr : sweep_ctr + FONT_BASE;
   assign font_off   = sweep_addr - FONT_BASE;
   assign in_font    = int'(font_off) < FONT_BYTES;
   assign sweep_byte = in_font ? font_byte : 8'h00;

   font_rom u_font_rom (
      .index (font_off[6:0]),
      .data  (font_byte)
   );

   assign busy = reset | (state == ST_INIT);

   // One fetch read port, shared by the high byte (IDLE) and low byte
   // (FETCH_LO); the low address wraps modulo the depth.
   assign fetch_rd_addr = (state == ST_FETCH_LO) ? fetch_addr_q + ADDR_WIDTH'(1)
                                                 : fetch_addr;
   assign fetch_byte    = mem[fetch_rd_addr];

   always_ff @(posedge clk) begin
      if (reset) state <= ST_INIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      fetch_ready = 1'b0;
      case (state)
         ST_INIT:     if (sweep_ctr == SWEEP_LAST) state_next = ST_IDLE;
         ST_IDLE: begin
            fetch_ready = ~reset;
            if (fetch_req) state_next = ST_FETCH_LO;
         end
         ST_FETCH_LO: state_next = ST_IDLE;
         default:     state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                 sweep_ctr <= '0;
      else if (state == ST_INIT) sweep_ctr <= sweep_ctr + ADDR_WIDTH'(1);
   end

   // Single write port: the sweep owns it while initialising, port A after.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_INIT) mem[sweep_addr] <= sweep_byte;
         else if (write)       mem[write_addr] <= write_data;
      end
   end

   // Reads sample the array before this edge's write lands (read-first).
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data    <= 8'h00;
         fetch_data   <= 16'h0000;
         fetch_valid  <= 1'b0;
         hi_reg       <= 8'h00;
         fetch_addr_q <= '0;
      end else begin
         fetch_valid <= 1'b0;
         if (state != ST_INIT && read) read_data <= mem[read_addr];
         if (state == ST_IDLE && fetch_req) begin
            fetch_addr_q <= fetch_addr;
            hi_reg       <= fetch_byte;
         end
         if (state == ST_FETCH_LO) begin
            fetch_data  <= {hi_reg, fetch_byte};
            fetch_valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/memory_ctrl.md
Name: memory_ctrl

Overview:
- Second-generation CHIP-8 main memory: a parametrised byte RAM with one read/write data port (port A) and one dedicated 16-bit big-endian instruction-fetch port (port F).
- On reset it runs a hardware initialisation sweep that zeroes the array and loads the built-in 80-byte hex font.
- Sits between the CPU core (data and fetch paths) and the display/loader logic.

Parameters:
- ADDR_WIDTH, 12: address width; memory depth is 2**ADDR_WIDTH bytes.
- FONT_BASE, 12'h000: byte address of font glyph 0; the font occupies FONT_BASE..FONT_BASE+79.
- CLEAR_ON_RESET, 1: 1 = full zero/font sweep after reset; 0 = only font bytes are written during the sweep and other bytes keep their contents.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high
- busy  output  1  high while reset is asserted or the init sweep runs
- read  input  1  port A read strobe
- read_addr  input  ADDR_WIDTH  port A read address
- read_data  output  8  port A read data, registered
- write  input  1  port A write strobe
- write_addr  input  ADDR_WIDTH  port A write address
- write_data  input  8  port A write data
- fetch_req  input  1  opcode fetch request
- fetch_addr  input  ADDR_WIDTH  address of opcode high byte
- fetch_ready  output  1  port F can accept fetch_req this cycle
- fetch_valid  output  1  one-cycle pulse; fetch_data is valid
- fetch_data  output  16  {mem[addr], mem[addr+1]}

Behaviour:
- Reset values: read_data=0, fetch_data=0, fetch_valid=0, fetch_ready=0, busy=1, sweep counter=0, FSM=INIT.
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset asserted mid-sweep or mid-fetch aborts the operation; the sweep restarts at address 0 and any pending fetch is dropped without a fetch_valid.
- INIT state:
  - Counter runs 0..2**ADDR_WIDTH-1, one byte per cycle. The byte written is font_rom[ctr-FONT_BASE] inside the font window, else 0.
  - With CLEAR_ON_RESET=0 the counter jumps FONT_BASE..FONT_BASE+79 only.
  - busy=1 throughout. After the last write: busy=0 and state=IDLE on the next edge.
  - While busy: port A reads and writes are ignored (read_data holds), and fetch_ready=0.
- Port A:
  - Read latency is 1: read sampled at edge N gives read_data valid after edge N. read_data holds when read=0.
  - Write commits at the edge.
  - Read and write to the same address in the same cycle is read-first: old data is returned.
  - Port A is fully independent of port F and is serviced in every non-busy cycle.
- Port F FSM (IDLE, FETCH_LO):
  - IDLE: fetch_ready=1. When fetch_req=1, latch fetch_addr, register mem[fetch_addr] into hi_reg, and go to FETCH_LO.
  - FETCH_LO: fetch_ready=0. Read mem[addr+1], where addr+1 is modulo 2**ADDR_WIDTH (0xFFF wraps to 0x000). Load fetch_data and pulse fetch_valid=1 for exactly one cycle. Return to IDLE.
  - Latency: request accepted at edge N gives fetch_valid high in the cycle after edge N+1. Maximum throughput is one fetch per 2 cycles.
  - fetch_req while fetch_ready=0 is ignored and not queued.
  - fetch_data holds its value between pulses.
- Simultaneous events: a port A write to addr or addr+1 lands in the same cycle as the corresponding fetch read. The fetch then returns the old byte (read-first). A write in an earlier cycle is visible.
- Storage: one write port and two read ports, suitable for a dual-port block RAM. No other initial-block clearing is used; contents are defined only after the first sweep.

Decomposition:
- Shared package/header: FONT_BYTES=80, fetch FSM state encodings, and the default memory depth constant.
- Sub-module font_rom: purely combinational, 7-bit index to 8-bit glyph byte (the standard 0-F glyph set, 5 bytes each). It is shared with any future loader.

Test Plan:
- Reset for 3 cycles, then release: busy stays 1 for exactly 4096 cycles, then drops. Port A reads 0x000 -> 0xF0, 0x004 -> 0xF0, 0x005 -> 0x20, 0x04F -> 0x80, 0x200 -> 0x00.
- After init, write 0x12 to 0x200 and 0x34 to 0x201, then fetch_req at 0x200: fetch_valid pulses 2 cycles later with fetch_data=0x1234, and fetch_ready is low for one cycle.
- Wrap-around: write 0xAB to 0xFFF and 0xCD to 0x000 (this overwrites font), then fetch at 0xFFF -> fetch_data=0xABCD.
- Collision: mem[0x300]=0x11, then read and write 0x300 with 0x22 in the same cycle -> read_data=0x11; the next read gives 0x22. Repeat for fetch: a FETCH_LO read of 0x301 concurrent with a write returns the old byte.
- Assert reset 100 cycles into the sweep and again during FETCH_LO: no fetch_valid occurs, the sweep restarts and busy lasts a full 4096 cycles. Port A writes issued while busy=1 are absent afterwards.
- CLEAR_ON_RESET=0, FONT_BASE=0x050: preload 0x77 at 0x300 via port A, then reset -> busy lasts 80 cycles, 0x050 reads 0xF0, and 0x300 still reads 0x77.
